// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: default instruction-code width, NOP code and
// the skid stage state encoding (value equals the number of held beats).
package pipe_pkg;
  localparam int CODE_W_DEF = 6;
  localparam logic [CODE_W_DEF-1:0] NOP_CODE_DEF = '0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b10
  } skid_state_e;
endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with async active-high reset and increment enable.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 cnt <= '0;
    else if (inc && cnt != '1) cnt <= cnt + W'(1);
  end
endmodule

// File: rtl/pipe_skid_reg.sv
// Pipeline stage register with a two-entry skid buffer. in_ready comes only
// from registered state, so back-pressure never forms a combinational path.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int                 DATA_W   = 96,
  parameter int                 CODE_W   = CODE_W_DEF,
  parameter logic [CODE_W-1:0]  NOP_CODE = CODE_W'(NOP_CODE_DEF),
  parameter int                 CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CODE_W-1:0] in_code,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);
  skid_state_e       state;
  logic [CODE_W-1:0] main_code, skid_code;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              accept, emit;

  assign in_ready  = (state != ST_FULL) & ~rst;
  assign out_valid = (state != ST_EMPTY);
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;

  // main is cleared whenever it empties, so outputs need no masking
  assign out_code  = main_code;
  assign out_data  = main_data;
  assign occupancy = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_EMPTY;
      main_code <= NOP_CODE;
      main_data <= '0;
      skid_code <= NOP_CODE;
      skid_data <= '0;
    end else if (flush) begin
      state     <= ST_EMPTY;
      main_code <= NOP_CODE;
      main_data <= '0;
      skid_code <= NOP_CODE;
      skid_data <= '0;
    end else begin
      case (state)
        ST_EMPTY: if (accept) begin
          main_code <= in_code;
          main_data <= in_data;
          state     <= ST_BUSY;
        end
        ST_BUSY: case ({accept, emit})
          2'b11: begin
            main_code <= in_code;
            main_data <= in_data;
          end
          2'b10: begin
            skid_code <= in_code;
            skid_data <= in_data;
            state     <= ST_FULL;
          end
          2'b01: begin
            main_code <= NOP_CODE;
            main_data <= '0;
            state     <= ST_EMPTY;
          end
          default: ;
        endcase
        ST_FULL: if (emit) begin
          main_code <= skid_code;
          main_data <= skid_data;
          skid_code <= NOP_CODE;
          skid_data <= '0;
          state     <= ST_BUSY;
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .inc (out_valid & ~out_ready),
    .cnt (stall_cnt)
  );
endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed bench: a queue model of the held beats checked every cycle, plus
// literal expectations from the hand-worked scenarios.
module tb_pipe_skid_reg;
  localparam int DW = 96;
  localparam int CW = 6;

  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [CW-1:0] in_code = '0;
  logic [DW-1:0] in_data = '0;
  logic in_ready, out_valid, in_ready4, out_valid4;
  logic [CW-1:0] out_code, out_code4;
  logic [DW-1:0] out_data, out_data4;
  logic [1:0] occupancy, occupancy4;
  logic [15:0] stall_cnt;
  logic [3:0] stall_cnt4;

  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  pipe_skid_reg dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_code(in_code), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_code(out_code), .out_data(out_data), .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  pipe_skid_reg #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
    .in_code(in_code), .in_data(in_data), .out_valid(out_valid4), .out_ready(out_ready),
    .out_code(out_code4), .out_data(out_data4), .occupancy(occupancy4), .stall_cnt(stall_cnt4)
  );

  typedef struct {
    logic [CW-1:0] code;
    logic [DW-1:0] data;
  } beat_t;

  beat_t mq[$];
  int    cnt16 = 0, cnt4 = 0;
  logic [CW-1:0] got[$];

  function automatic logic [DW-1:0] mkdata(input logic [CW-1:0] c);
    mkdata = {32'hA5A5_0000 | 32'(c), 32'(c) * 32'h0101_0101, 32'hDEAD_0000 ^ 32'(c)};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  // Reference: the stage holds an ordered list of at most two beats.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      cnt16 = 0;
      cnt4  = 0;
    end else begin
      automatic bit acc = in_valid && (mq.size() < 2);
      automatic bit em  = (mq.size() > 0) && out_ready;
      automatic beat_t b;
      b.code = in_code;
      b.data = in_data;
      if (mq.size() > 0 && !out_ready) begin
        if (cnt16 != 65535) cnt16++;
        if (cnt4 != 15) cnt4++;
      end
      if (flush) mq.delete();
      else begin
        if (em) void'(mq.pop_front());
        if (acc) mq.push_back(b);
      end
    end
  end

  always @(negedge clk) begin
    automatic bit ev = mq.size() > 0;
    chk("in_ready", in_ready, (mq.size() < 2) && !rst);
    chk("out_valid", out_valid, ev);
    chk("out_code", out_code, ev ? mq[0].code : '0);
    chk("out_data", out_data, ev ? mq[0].data : '0);
    chk("occupancy", occupancy, mq.size());
    chk("stall_cnt", stall_cnt, cnt16);
    chk("stall_cnt4", stall_cnt4, cnt4);
    if (out_valid && out_ready) got.push_back(out_code);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [CW-1:0] c);
    in_valid = 1;
    in_code  = c;
    in_data  = mkdata(c);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    // reset with a beat on offer
    offer(7);
    step(); step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_code", out_code, 0);
    rst = 0;
    offer(7);
    in_data = 96'h1F;
    step();
    chk("lat_valid", out_valid, 1);
    chk("lat_code", out_code, 7);
    chk("lat_data", out_data, 96'h1F);
    in_valid = 0; out_ready = 1;
    step(); step();

    // streaming
    got.delete();
    for (int i = 1; i <= 8; i++) begin
      offer(CW'(i));
      step();
      chk("stream_occ", occupancy, 1);
    end
    in_valid = 0;
    step(); step();
    chk("stream_n", got.size(), 8);
    for (int i = 0; i < 8 && i < got.size(); i++) chk("stream_order", got[i], i + 1);
    chk("stream_stall", stall_cnt, 0);

    // back-pressure
    got.delete();
    out_ready = 0;
    offer(1); step();
    offer(2); step();
    chk("bp_in_ready", in_ready, 0);
    chk("bp_occ", occupancy, 2);
    offer(3);
    step(); step(); step();
    out_ready = 1;
    step(); step();
    in_valid = 0;
    step(); step();
    chk("bp_n", got.size(), 3);
    for (int i = 0; i < 3 && i < got.size(); i++) chk("bp_order", got[i], i + 1);
    chk("bp_stall", stall_cnt, 4);

    // flush while full
    got.delete();
    out_ready = 0;
    offer(4); step();
    offer(5); step();
    chk("fl_pre_occ", occupancy, 2);
    flush = 1;
    offer(9);
    step();
    flush = 0; in_valid = 0;
    chk("fl_occ", occupancy, 0);
    chk("fl_valid", out_valid, 0);
    chk("fl_code", out_code, 0);
    chk("fl_stall", stall_cnt, 6);
    out_ready = 1;
    step(); step();
    chk("fl_nothing_out", got.size(), 0);

    // saturation of the narrow counter
    out_ready = 0;
    offer(10); step();
    in_valid = 0;
    repeat (20) step();
    chk("sat4", stall_cnt4, 15);
    chk("sat16", stall_cnt, 26);

    // async reset between edges with two beats held
    offer(11); step();
    in_valid = 0;
    chk("ar_pre_occ", occupancy, 2);
    #2 rst = 1;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_occ", occupancy, 0);
    chk("ar_code", out_code, 0);
    chk("ar_data", out_data, 0);
    chk("ar_stall", stall_cnt, 0);
    chk("ar_stall4", stall_cnt4, 0);
    chk("ar_in_ready", in_ready, 0);
    got.delete();
    step();
    rst = 0;
    out_ready = 1;
    step(); step();
    chk("ar_in_ready_post", in_ready, 1);
    chk("ar_nothing_out", got.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
